// File: rtl/ram_burst_reader_if.sv
// Bundles the command, RAM read port and output stream of ram_burst_reader.
// The master modport is the burst reader's view; slave is the view of the
// logic around it (command source, RAM and stream consumer).
interface ram_burst_reader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 9
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [LEN_WIDTH-1:0]  length;
   logic                  busy;
   logic                  done;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  m_ready;

   modport master (
      input  start, base_addr, length, ram_data_out, m_ready,
      output busy, done, ram_we, ram_addr, m_valid, m_data, m_last
   );

   modport slave (
      output start, base_addr, length, ram_data_out, m_ready,
      input  busy, done, ram_we, ram_addr, m_valid, m_data, m_last
   );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a single-port RAM with one-cycle registered read
// latency. Issues sequential (wrapping) addresses, captures the returned words
// into a 4-entry FIFO and presents them as a valid/ready stream with m_last.
// Issue is credit-limited so words in flight plus buffered never exceed 4.
module ram_burst_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 9
) (
   input logic              clk,
   input logic              rst_n,
   ram_burst_reader_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  left_q, left_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d;
   logic                  issue_q, issue_d;
   logic                  cap_q, cap_d;
   logic                  done_q, done_d;
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [2:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] fifo_q [4];

   logic                  head_valid;
   logic                  pop;
   logic                  last_beat;
   logic [3:0]            in_flight;
   logic                  can_issue;

   // Handshake, last-beat and credit decode shared by the next-state logic
   always_comb begin
      head_valid = (count_q != 3'd0);
      pop        = head_valid & bus.m_ready;
      last_beat  = (beat_q == (len_q - LEN_ONE));
      in_flight  = {1'b0, count_q} + {3'b000, issue_q} + {3'b000, cap_q};
      // A new address may go out only if, after this cycle's pop, there is
      // room for it on top of everything already buffered or in flight.
      can_issue  = (left_q != '0) && (in_flight < (4'd4 + {3'b000, pop}));
   end

   // State and datapath registers; reset discards any burst in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         left_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         issue_q  <= 1'b0;
         cap_q    <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         left_q   <= left_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         issue_q  <= issue_d;
         cap_q    <= cap_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage: the RAM word addressed last cycle is written when cap_q is set
   always_ff @(posedge clk) begin
      if (cap_q) begin
         fifo_q[wr_ptr_q] <= bus.ram_data_out;
      end
   end

   // Next-state logic: the burst ends on the handshake of its last word
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.length != '0)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (pop && last_beat) begin
               state_d = S_IDLE;
            end else if (left_q == '0) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && last_beat) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: address issue, capture pipeline, FIFO and beat count
   always_comb begin
      addr_d   = addr_q;
      left_d   = left_q;
      len_d    = len_q;
      beat_d   = beat_q;
      issue_d  = 1'b0;
      cap_d    = issue_q;
      done_d   = 1'b0;
      wr_ptr_d = cap_q ? (wr_ptr_q + 2'd1) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q + 2'd1) : rd_ptr_q;
      count_d  = count_q + {2'b00, cap_q} - {2'b00, pop};

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.length != '0) begin
                  // The first address goes out on the accepting edge itself.
                  addr_d  = bus.base_addr;
                  issue_d = 1'b1;
                  left_d  = bus.length - LEN_ONE;
                  len_d   = bus.length;
                  beat_d  = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (can_issue) begin
               addr_d  = addr_q + ADDR_ONE;
               issue_d = 1'b1;
               left_d  = left_q - LEN_ONE;
            end
         end
         default: ;
      endcase

      if ((state_q != S_IDLE) && pop) begin
         beat_d = beat_q + LEN_ONE;
         if (last_beat) begin
            done_d = 1'b1;
         end
      end
   end

   // Outputs: stream comes straight from the FIFO head, m_last from the beat counter
   always_comb begin
      bus.busy     = (state_q != S_IDLE);
      bus.done     = done_q;
      bus.ram_we   = 1'b0;
      bus.ram_addr = addr_q;
      bus.m_valid  = head_valid;
      bus.m_data   = head_valid ? fifo_q[rd_ptr_q] : '0;
      bus.m_last   = head_valid & last_beat;
   end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a registered-read RAM model.
module tb_ram_burst_reader;

   logic clk = 1'b0;
   logic rst_n;

   ram_burst_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LEN_WIDTH(9)) bus ();

   ram_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LEN_WIDTH(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] tb_mem [256];

   // RAM model: one-cycle registered read
   always @(posedge clk) bus.ram_data_out <= tb_mem[bus.ram_addr];

   int errors = 0;
   int checks = 0;

   logic [15:0] bd[$];
   logic        bl[$];
   int          bc[$];
   int          done_cyc, done_cnt;
   logic        busy_seen, we_seen, busy_at_done, busy_at1;
   logic        prev_hold;
   logic [15:0] prev_data;
   logic [7:0]  addr_tr [16];
   bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bdat(input int i);
      return (i < bd.size()) ? bd[i] : 16'hxxxx;
   endfunction

   function automatic int bcyc(input int i);
      return (i < bc.size()) ? bc[i] : -1;
   endfunction

   function automatic logic blast(input int i);
      return (i < bl.size()) ? bl[i] : 1'bx;
   endfunction

   function automatic int last_count();
      int n = 0;
      foreach (bl[i]) if (bl[i] === 1'b1) n++;
      return n;
   endfunction

   // Issue one start, then run cycle by cycle (k=1 is the cycle after the
   // accepting edge), recording handshakes, done and the address trace.
   task automatic run_burst(input logic [7:0] b, input logic [8:0] l, input bit bp,
                            input int inj_k, input int budget);
      bd.delete(); bl.delete(); bc.delete();
      done_cyc = -1; done_cnt = 0;
      busy_seen = 1'b0; we_seen = 1'b0; busy_at_done = 1'b0; busy_at1 = 1'b0;
      prev_hold = 1'b0; prev_data = '0;
      for (int i = 0; i < 16; i++) addr_tr[i] = 8'h00;
      bus.start = 1'b1; bus.base_addr = b; bus.length = l; bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         bus.m_ready = bp ? pat[(k-1) % 6] : 1'b1;
         if (k == inj_k) begin
            bus.start = 1'b1; bus.base_addr = 8'h80; bus.length = 9'd2;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         if (k < 16) addr_tr[k] = bus.ram_addr;
         if (k == 1) busy_at1 = bus.busy;
         busy_seen = busy_seen | bus.busy;
         we_seen   = we_seen | bus.ram_we;
         if (prev_hold) begin
            check("hold_valid", {31'd0, bus.m_valid}, 32'd1);
            check("hold_data", {16'd0, bus.m_data}, {16'd0, prev_data});
         end
         prev_hold = bus.m_valid && !bus.m_ready;
         prev_data = bus.m_data;
         if (bus.m_valid && bus.m_ready) begin
            bd.push_back(bus.m_data); bl.push_back(bus.m_last); bc.push_back(k);
         end
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = k; busy_at_done = bus.busy;
            end
         end
         @(posedge clk); #1;
         if (done_cyc >= 0 && k >= done_cyc + 2) break;
      end
      bus.start = 1'b0; bus.m_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int mism, dc, vc;
      for (int i = 0; i < 256; i++) tb_mem[i] = {i[7:0] ^ 8'h3C, i[7:0]};
      tb_mem[8'h10] = 16'h00A0; tb_mem[8'h11] = 16'h00A1;
      tb_mem[8'h12] = 16'h00A2; tb_mem[8'h13] = 16'h00A3;

      rst_n = 1'b0;
      bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
      check("rst_m_data", {16'd0, bus.m_data}, 32'd0);
      check("rst_m_last", {31'd0, bus.m_last}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_ram_addr", {24'd0, bus.ram_addr}, 32'd0);
      check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic burst, full throughput
      run_burst(8'h10, 9'd4, 1'b0, 0, 20);
      check("basic_nbeats", bd.size(), 32'd4);
      check("basic_d01", {bdat(0), bdat(1)}, 32'h00A000A1);
      check("basic_d23", {bdat(2), bdat(3)}, 32'h00A200A3);
      check("basic_first_cyc", bcyc(0), 32'd3);
      check("basic_last_cyc", bcyc(3), 32'd6);
      check("basic_last_flag", {31'd0, blast(3)}, 32'd1);
      check("basic_last_count", last_count(), 32'd1);
      check("basic_done_cyc", done_cyc, 32'd7);
      check("basic_done_cnt", done_cnt, 32'd1);
      check("basic_busy_at_done", {31'd0, busy_at_done}, 32'd0);
      check("basic_busy_k1", {31'd0, busy_at1}, 32'd1);
      check("basic_addr_k1_k4", {addr_tr[1], addr_tr[2], addr_tr[3], addr_tr[4]}, 32'h10111213);
      check("basic_we", {31'd0, we_seen}, 32'd0);

      // Backpressure 1,0,0,1,0,1 on the same burst
      run_burst(8'h10, 9'd4, 1'b1, 0, 40);
      check("bp_nbeats", bd.size(), 32'd4);
      check("bp_d01", {bdat(0), bdat(1)}, 32'h00A000A1);
      check("bp_d23", {bdat(2), bdat(3)}, 32'h00A200A3);
      check("bp_first_cyc", bcyc(0), 32'd4);
      check("bp_last_cyc", bcyc(3), 32'd10);
      check("bp_last_flag", {31'd0, blast(3)}, 32'd1);
      check("bp_last_count", last_count(), 32'd1);
      check("bp_done_cyc", done_cyc, 32'd11);

      // Longer burst under backpressure exercises the issue credit limit
      run_burst(8'h30, 9'd12, 1'b1, 0, 100);
      check("bp12_nbeats", bd.size(), 32'd12);
      mism = 0;
      for (int i = 0; i < bd.size(); i++)
         if (bd[i] !== tb_mem[8'(8'h30 + i)]) mism++;
      check("bp12_data_mism", mism, 32'd0);
      check("bp12_last_flag", {31'd0, blast(11)}, 32'd1);
      check("bp12_last_count", last_count(), 32'd1);
      check("bp12_done_after_last", done_cyc, bcyc(11) + 1);

      // Address wrap 0xFE -> 0x01
      run_burst(8'hFE, 9'd4, 1'b0, 0, 20);
      check("wrap_addr", {addr_tr[1], addr_tr[2], addr_tr[3], addr_tr[4]}, 32'hFEFF0001);
      check("wrap_d01", {bdat(0), bdat(1)}, 32'hC2FEC3FF);
      check("wrap_d23", {bdat(2), bdat(3)}, 32'h3C003D01);
      check("wrap_done_cyc", done_cyc, 32'd7);

      // Zero length
      run_burst(8'h50, 9'd0, 1'b0, 0, 10);
      check("zero_done_cyc", done_cyc, 32'd1);
      check("zero_nbeats", bd.size(), 32'd0);
      check("zero_busy_seen", {31'd0, busy_seen}, 32'd0);

      // Start while busy is ignored
      run_burst(8'h10, 9'd4, 1'b0, 2, 20);
      check("busystart_nbeats", bd.size(), 32'd4);
      check("busystart_d01", {bdat(0), bdat(1)}, 32'h00A000A1);
      check("busystart_d23", {bdat(2), bdat(3)}, 32'h00A200A3);
      check("busystart_done_cyc", done_cyc, 32'd7);
      check("busystart_done_cnt", done_cnt, 32'd1);

      // Reset after two beats of an 8-word burst
      bd.delete(); bl.delete(); bc.delete();
      bus.start = 1'b1; bus.base_addr = 8'h20; bus.length = 9'd8; bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (bus.m_valid && bus.m_ready) begin
            bd.push_back(bus.m_data); bl.push_back(bus.m_last); bc.push_back(k);
         end
         @(posedge clk); #1;
      end
      check("midrst_pre_nbeats", bd.size(), 32'd2);
      check("midrst_pre_data", {bdat(0), bdat(1)}, 32'h1C201D21);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
      check("midrst_m_data", {16'd0, bus.m_data}, 32'd0);
      check("midrst_m_last", {31'd0, bus.m_last}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_done", {31'd0, bus.done}, 32'd0);
      check("midrst_ram_addr", {24'd0, bus.ram_addr}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      dc = 0; vc = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done) dc++;
         if (bus.m_valid) vc++;
         @(posedge clk); #1;
      end
      check("midrst_no_done", dc, 32'd0);
      check("midrst_no_valid", vc, 32'd0);

      run_burst(8'h40, 9'd3, 1'b0, 0, 20);
      check("postrst_nbeats", bd.size(), 32'd3);
      check("postrst_d01", {bdat(0), bdat(1)}, 32'h7C407D41);
      check("postrst_d2", {16'd0, bdat(2)}, 32'h00007E42);
      check("postrst_last_flag", {31'd0, blast(2)}, 32'd1);
      check("postrst_done_cyc", done_cyc, 32'd6);

      // Full 256-word burst with complete address wrap
      run_burst(8'h00, 9'd256, 1'b0, 0, 300);
      check("full_nbeats", bd.size(), 32'd256);
      mism = 0;
      for (int i = 0; i < bd.size(); i++)
         if (bd[i] !== tb_mem[i[7:0]]) mism++;
      check("full_data_mism", mism, 32'd0);
      check("full_last_flag", {31'd0, blast(255)}, 32'd1);
      check("full_last_count", last_count(), 32'd1);
      check("full_last_cyc", bcyc(255), 32'd258);
      check("full_done_cyc", done_cyc, 32'd259);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side initiator for the single-port neuron RAM. On a `start` command it issues `length` sequential reads from `base_addr`, with addresses wrapping modulo 2^ADDR_WIDTH. It absorbs the RAM's one-cycle registered read latency and presents the words as a valid/ready stream with a last marker. It sits between a weight/activation RAM and the MAC datapath, and reaches full throughput of one word per cycle.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width.
- `DATA_WIDTH`, default 16: RAM and stream word width.
- `LEN_WIDTH`, default 9: width of `length`. Maximum burst is 2^LEN_WIDTH-1 words.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: burst command, sampled only while idle.
- `base_addr`  in  ADDR_WIDTH: first address, captured with `start`.
- `length`  in  LEN_WIDTH: word count, captured with `start`.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse at burst end.
- `ram_we`  out  1: RAM write enable, constant 0.
- `ram_addr`  out  ADDR_WIDTH: registered RAM address.
- `ram_data_out`  in  DATA_WIDTH: RAM registered read data.
- `m_valid`  out  1: stream word valid.
- `m_data`  out  DATA_WIDTH: stream word.
- `m_last`  out  1: marks the final word of the burst, qualified by `m_valid`.
- `m_ready`  in  1: downstream accept.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `start`=1 and `length`≠0 → capture `base_addr` and `length`, go to RUN.
  - `start`=1 and `length`=0 → pulse `done` in the next cycle. No beats are produced and `busy` never rises.
- **RUN:** issues one address per cycle while credit is available.
  - `ram_addr` ← next address; `issue_q` ← 1; remaining issue count decrements.
  - Address increments modulo 2^ADDR_WIDTH, so 0xFF is followed by 0x00.
  - When the last address has been issued → DRAIN.
- **Pipeline:**
  - `issue_q` in cycle N means `ram_addr` is valid in cycle N. The RAM loads `ram_data_out` at the end of cycle N.
  - `cap_q` in cycle N+1 writes `ram_data_out` into a 4-entry output FIFO at the end of N+1.
- **Credit rule:** issue only when `fifo_count + issue_q + cap_q - (m_valid & m_ready) < 4`. The FIFO therefore never overflows. No data is lost under any `m_ready` pattern.
- **Output stream:**
  - `m_valid`/`m_data` come from the FIFO head.
  - A word transfers on `m_valid & m_ready`.
  - Once `m_valid` is high, it and `m_data` hold until accepted.
- **`m_last`:** high with the word whose stream index is `length`-1. Generated from a separate beat counter, not from the FIFO.
- **DRAIN:** waits until the last word is handshaken.
  - In the cycle after that handshake: `done`=1, `busy`=0, state → IDLE.
- **`busy`:** 1 in RUN and DRAIN.
- **`start` while busy:** ignored. Inputs are not recaptured.
- **`ram_we`:** tied to 0. This block never writes the RAM.
- **Reset (asynchronous, including mid-burst):**
  - state → IDLE; FIFO and pipeline flags cleared.
  - Outputs: `ram_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0.
  - In-flight words are discarded. No `done` is produced for the aborted burst.

## Timing
- **Start latency:** `start` sampled at edge E0.
  - `ram_addr`=base in cycle E0+1.
  - Data captured at end of E0+2.
  - `m_valid`=1 in cycle E0+3.
  - Start-to-first-word latency is 3 cycles.
- **Throughput:** with `m_ready` held high, one word per cycle and no bubbles after the first word. A burst of L words completes its last handshake in cycle E0+2+L.
- **Done:** asserted the cycle after the last handshake. A new `start` is accepted in that same `done` cycle.
- **Backpressure:**
  - `m_ready` low stalls issue within at most 3 further addresses.
  - Issue resumes the cycle after credit frees.
- **Zero length:** `start` at E0 → `done`=1 in cycle E0+1.

## Test plan
- **Basic burst:** RAM[0x10..0x13]=A0,A1,A2,A3; base=0x10, len=4, `m_ready`=1.
  - Beats A0..A3 in consecutive cycles starting at E0+3.
  - `m_last` on A3; `done` in E0+7.
- **Backpressure:** same burst with `m_ready` toggling 1,0,0,1,0,1…
  - Exactly A0..A3 in order, none dropped or duplicated.
  - `m_data` stable while `m_valid`=1 and `m_ready`=0.
  - FIFO occupancy never exceeds 4.
- **Wrap:** base=0xFE, len=4.
  - `ram_addr` sequence 0xFE, 0xFF, 0x00, 0x01; data matches those locations.
- **Zero length and busy start:**
  - len=0 → `done` at E0+1, no `m_valid`.
  - `start` asserted during a running burst → ignored; the original burst completes unchanged.
- **Reset mid-burst:** assert `rst_n`=0 after 2 beats of a len=8 burst.
  - All outputs 0 immediately; no `done`.
  - A new burst after release streams correctly from its own base.
- **Full length:** len=256, base=0x00, `m_ready`=1.
  - 256 beats, full address wrap, `m_last` only on beat 255.
